// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART packet deframer: FSM states, status codes,
// default sync marker and the modulo-256 checksum helper.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } frame_err_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TIMEOUT.
module uart_frame_timeout #(
    parameter int TIMEOUT = 100000,
    parameter int TO_W    = 17
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Expiry is flagged on the enabled cycle that completes the TIMEOUT-th count.
    assign expired_o = en_i & (cnt_q == TO_W'(TIMEOUT - 1));

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Packet deframer behind the UART RX FIFO: hunts for SYNC, reads LEN, streams
// payload on valid/ready, checks the checksum and reports per-frame status.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int          MAX_LEN  = 64,
    parameter int          TIMEOUT  = 100000,
    parameter int          TO_W     = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       frame_done,
    output logic [1:0] frame_err,
    output logic       busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] m_data_q, m_data_d;
    logic       m_valid_q, m_valid_d;
    logic       m_last_q, m_last_d;
    logic       done_q, done_d;
    frame_err_e err_q, err_d;
    logic       can_take_s;
    logic       fetch_s;
    logic       expired_s;

    // Fetch permission per state; CSUM waits for the last payload byte to leave.
    always_comb begin
        can_take_s = 1'b0;
        case (state_q)
            ST_HUNT:    can_take_s = 1'b1;
            ST_LEN:     can_take_s = 1'b1;
            ST_PAYLOAD: can_take_s = ~m_valid_q | m_ready;
            ST_CSUM:    can_take_s = ~m_valid_q;
            default:    can_take_s = 1'b0;
        endcase
    end

    // Reset gates the pop so no byte is lost while the block is held in reset.
    assign fetch_s = ~rx_empty & can_take_s & reset;

    uart_frame_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (fetch_s | (state_q == ST_HUNT)),
        .en_i      ((state_q != ST_HUNT) & rx_empty),
        .expired_o (expired_s)
    );

    // Frame FSM, checksum accumulator and payload output register.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        done_d    = 1'b0;
        err_d     = err_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end

        case (state_q)
            ST_HUNT: begin
                if (fetch_s && (r_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                    acc_d   = 8'h00;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_LEN: begin
                if (fetch_s) begin
                    if (r_data > MAX_LEN_B) begin
                        done_d  = 1'b1;
                        err_d   = ERR_LEN;
                        state_d = ST_HUNT;
                    end else if (r_data == 8'h00) begin
                        acc_d   = r_data;
                        state_d = ST_CSUM;
                    end else begin
                        acc_d   = r_data;
                        cnt_d   = r_data;
                        state_d = ST_PAYLOAD;
                    end
                end else if (expired_s) begin
                    done_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_HUNT;
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_PAYLOAD: begin
                if (fetch_s) begin
                    m_data_d  = r_data;
                    m_valid_d = 1'b1;
                    m_last_d  = (cnt_q == 8'd1);
                    acc_d     = csum_add(acc_q, r_data);
                    cnt_d     = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else if (expired_s) begin
                    done_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_HUNT;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_CSUM: begin
                if (fetch_s) begin
                    done_d  = 1'b1;
                    state_d = ST_HUNT;
                    if (csum_add(acc_q, r_data) == 8'h00) begin
                        err_d = ERR_OK;
                    end else begin
                        err_d = ERR_CSUM;
                    end
                end else if (expired_s) begin
                    done_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_HUNT;
                end else begin
                    state_d = ST_CSUM;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_HUNT;
            acc_q     <= 8'h00;
            cnt_q     <= 8'h00;
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= ERR_OK;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign rd_uart    = fetch_s;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != ST_HUNT);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: a queue-backed FIFO model feeds bytes,
// expected payload/status entries are queued with the stimulus and popped on output.
module tb_uart_frame_rx;

    localparam int TMO = 50;

    typedef struct {
        logic [1:0] err;
        int         lat;
    } st_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready = 1'b1;
    logic       frame_done;
    logic [1:0] frame_err;
    logic       busy;

    logic [7:0] fifo[$];
    logic [8:0] exp_pl[$];
    st_t        exp_st[$];

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  last_rd_cyc = 0;
    int  rd_cnt = 0;
    int  viol_empty = 0;
    int  viol_stall = 0;
    bit  pop_pend = 1'b0;
    bit  bp_mode = 1'b0;
    bit  ready_lvl = 1'b1;
    bit  done_ok;

    uart_frame_rx #(
        .SYNC_BYTE (8'hA5),
        .MAX_LEN   (64),
        .TIMEOUT   (TMO),
        .TO_W      (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd_uart    (rd_uart),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // FIFO model and m_ready driver, updated just after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
        pop_pend = 1'b0;
        rx_empty = (fifo.size() == 0);
        r_data   = rx_empty ? 8'h00 : fifo[0];
        m_ready  = bp_mode ? ((cyc % 4) == 0) : ready_lvl;
    end

    // Output monitor on the falling edge: scoreboard pops and protocol checks.
    always @(negedge clk) begin
        if (reset) begin
            if (frame_done) begin
                if (exp_st.size() == 0) begin
                    check_val("unexpected_done", 32'd1, 32'd0);
                end else begin
                    st_t e;
                    e = exp_st.pop_front();
                    check_val("frame_err", {30'd0, frame_err}, {30'd0, e.err});
                    check_val("done_latency", cyc - last_rd_cyc, e.lat);
                end
            end
            if (m_valid && m_ready) begin
                if (exp_pl.size() == 0) begin
                    check_val("unexpected_payload", {23'd0, m_last, m_data}, 32'h1FF);
                end else begin
                    logic [8:0] p;
                    p = exp_pl.pop_front();
                    check_val("m_data", {24'd0, m_data}, {24'd0, p[7:0]});
                    check_val("m_last", {31'd0, m_last}, {31'd0, p[8]});
                end
            end
            if (rd_uart) begin
                if (rx_empty) viol_empty++;
                if (m_valid && !m_ready) viol_stall++;
                pop_pend    = 1'b1;
                rd_cnt++;
                last_rd_cyc = cyc + 1;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic exp_byte(input logic [7:0] b, input bit last);
        exp_pl.push_back({last, b});
    endtask

    task automatic exp_status(input logic [1:0] err, input int lat);
        st_t s;
        s.err = err;
        s.lat = lat;
        exp_st.push_back(s);
    endtask

    // Well-formed frame with payload base + i*step; checksum from the byte sum.
    task automatic good_frame(input int n, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'(n);
        push(8'hA5);
        push(8'(n));
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i) * step;
            sum = sum + b;
            push(b);
            exp_byte(b, i == n - 1);
        end
        push(8'h00 - sum);
        exp_status(2'd0, 0);
    endtask

    task automatic drain(input string tag, input int max_cyc);
        done_ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            if (fifo.size() == 0 && exp_pl.size() == 0 && exp_st.size() == 0 && !busy) begin
                done_ok = 1'b1;
                break;
            end
        end
        if (!done_ok) check_val({tag, "_drain"}, 32'd0, 32'd1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        // Reset held with a noise byte waiting: nothing may be popped.
        push(8'h33);
        repeat (3) @(negedge clk);
        check_val("rst_rd_uart", {31'd0, rd_uart}, 32'd0);
        check_val("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check_val("rst_m_data", {24'd0, m_data}, 32'd0);
        check_val("rst_m_last", {31'd0, m_last}, 32'd0);
        check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_val("rst_frame_err", {30'd0, frame_err}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        drain("noise0", 20);

        // Worked-example good frame.
        rd_cnt = 0;
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h97);
        exp_byte(8'h11, 1'b0); exp_byte(8'h22, 1'b0); exp_byte(8'h33, 1'b1);
        exp_status(2'd0, 0);
        drain("good", 50);
        check_val("good_rd_pulses", rd_cnt, 32'd6);

        // Bad checksum, then an empty frame.
        push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'h00);
        exp_byte(8'h10, 1'b0); exp_byte(8'h20, 1'b1);
        exp_status(2'd1, 0);
        push(8'hA5); push(8'h00); push(8'h00);
        exp_status(2'd0, 0);
        drain("csum", 50);

        // Noise then an oversize LEN.
        push(8'h00); push(8'hFF); push(8'hA5); push(8'h41);
        exp_status(2'd2, 0);
        drain("len", 50);

        // Backpressure with SYNC value inside the payload.
        bp_mode = 1'b1;
        good_frame(5, 8'h9E, 8'h07);
        drain("bp", 200);
        bp_mode = 1'b0;
        check_val("bp_fetch_while_stalled", viol_stall, 32'd0);

        // Long downstream stall with bytes waiting must not time out.
        ready_lvl = 1'b0;
        good_frame(4, 8'h40, 8'h03);
        repeat (3 * TMO) @(posedge clk);
        check_val("stall_busy", {31'd0, busy}, 32'd1);
        check_val("stall_status_pending", exp_st.size(), 32'd1);
        ready_lvl = 1'b1;
        drain("stall", 50);

        // Inter-byte timeout after A5 04 01.
        push(8'hA5); push(8'h04); push(8'h01);
        exp_byte(8'h01, 1'b0);
        exp_status(2'd3, TMO);
        drain("timeout", 4 * TMO);
        check_val("timeout_busy", {31'd0, busy}, 32'd0);
        good_frame(2, 8'h5A, 8'h11);
        drain("after_timeout", 50);

        // Asynchronous reset in the middle of the payload.
        good_frame(8, 8'h10, 8'h01);
        done_ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (exp_pl.size() <= 5) begin
                done_ok = 1'b1;
                break;
            end
        end
        check_val("midframe_reached", {31'd0, done_ok}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_val("arst_m_valid", {31'd0, m_valid}, 32'd0);
        check_val("arst_busy", {31'd0, busy}, 32'd0);
        check_val("arst_rd_uart", {31'd0, rd_uart}, 32'd0);
        check_val("arst_m_data", {24'd0, m_data}, 32'd0);
        exp_pl.delete();
        exp_st.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check_val("post_rst_busy", {31'd0, busy}, 32'd0);
        good_frame(3, 8'hC0, 8'h05);
        drain("post_reset", 100);

        check_val("rd_while_empty", viol_empty, 32'd0);
        check_val("payload_left", exp_pl.size(), 32'd0);
        check_val("status_left", exp_st.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
